// File: rtl/c1908_pkg.sv
// Shared widths, bus field indices, codeword position table and check-bit
// generator for the c1908 SEC/DED codec.
package c1908_pkg;

  localparam int DATA_W = 16;
  localparam int HAM_W  = 5;
  localparam int WORD_W = DATA_W + HAM_W + 1;
  localparam int IN_W   = 33;
  localparam int OUT_W  = 25;

  localparam int G_DATA_LSB = 0;
  localparam int G_CHK_LSB  = 16;
  localparam int G_PAR      = 21;
  localparam int G_CORR_EN  = 22;
  localparam int G_ENC_MODE = 23;
  localparam int G_INJ_LSB  = 24;
  localparam int G_INJ_EN   = 29;
  localparam int G_RSV_LSB  = 30;
  localparam int G_VALID    = 32;

  localparam int O_DATA_LSB = 0;
  localparam int O_SYN_LSB  = 16;
  localparam int O_PERR     = 21;
  localparam int O_SERR     = 22;
  localparam int O_DERR     = 23;
  localparam int O_VALID    = 24;

  // Codeword position of each data bit; powers of two are reserved for checks.
  localparam logic [HAM_W-1:0] DATA_POS [DATA_W] = '{
    5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12,
    5'd13, 5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21
  };

  function automatic logic [HAM_W-1:0] calc_check(input logic [DATA_W-1:0] d);
    logic [HAM_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      for (int k = 0; k < HAM_W; k++) begin
        if (DATA_POS[i][k]) c[k] = c[k] ^ d[i];
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/c1908_syndrome.sv
// Combinational syndrome and overall-parity generator over the 22-bit
// received word {parity, h4..h0, data}.
module c1908_syndrome
  import c1908_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic [HAM_W-1:0]  syn_o,
  output logic              pe_o
);

  // Each check bit sits alone at position 2^k, so it folds straight into s[k].
  always_comb begin
    syn_o = calc_check(word_i[DATA_W-1:0]) ^ word_i[G_CHK_LSB +: HAM_W];
    pe_o  = ^word_i;
  end

endmodule

// File: rtl/c1908_secded.sv
// Registered 16-bit SEC/DED codec with encode mode and single-bit injection.
// Define C1908_INPUT_REG_EN to add an input register stage (latency 2).
module c1908_secded
  import c1908_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] g_in,
  output logic [OUT_W-1:0] o_out
);

  logic [IN_W-1:0]   g_eff;
  logic [WORD_W-1:0] word_inj;
  logic [WORD_W-1:0] syn_in;
  logic [HAM_W-1:0]  syn;
  logic              pe;
  logic [DATA_W-1:0] data_fix;
  logic              single_err;
  logic              double_err;
  logic [OUT_W-1:0]  o_d, o_q;
  logic              unused_rsv;

`ifdef C1908_INPUT_REG_EN
  logic [IN_W-1:0] g_d, g_q;

  always_comb begin
    g_d = g_in;
  end

  always_ff @(posedge clk) begin
    if (rst) g_q <= '0;
    else     g_q <= g_d;
  end

  assign g_eff = g_q;
`else
  assign g_eff = g_in;
`endif

  assign unused_rsv = ^g_eff[G_RSV_LSB +: 2];

  always_comb begin
    word_inj = g_eff[WORD_W-1:0];
    if (g_eff[G_INJ_EN]) begin
      for (int i = 0; i < WORD_W; i++) begin
        if (g_eff[G_INJ_LSB +: 5] == 5'(i)) word_inj[i] = ~word_inj[i];
      end
    end
  end

  // Encode reuses the syndrome path: with checks and parity zeroed, s is the check word.
  assign syn_in = g_eff[G_ENC_MODE] ? {{(WORD_W-DATA_W){1'b0}}, word_inj[DATA_W-1:0]}
                                    : word_inj;

  c1908_syndrome u_syndrome (
    .word_i (syn_in),
    .syn_o  (syn),
    .pe_o   (pe)
  );

  always_comb begin
    data_fix   = word_inj[DATA_W-1:0];
    single_err = 1'b0;
    double_err = 1'b0;
    if (pe) begin
      if (syn <= 5'(WORD_W-1)) single_err = 1'b1;
      else                     double_err = 1'b1;
    end else if (syn != '0) begin
      double_err = 1'b1;
    end
    if (single_err && g_eff[G_CORR_EN]) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (syn == DATA_POS[i]) data_fix[i] = ~data_fix[i];
      end
    end
  end

  // Idle cycles keep the last result visible and only drop out_valid.
  always_comb begin
    o_d          = o_q;
    o_d[O_VALID] = 1'b0;
    if (g_eff[G_VALID]) begin
      o_d[O_VALID] = 1'b1;
      o_d[O_SYN_LSB +: HAM_W] = syn;
      if (g_eff[G_ENC_MODE]) begin
        o_d[O_DATA_LSB +: DATA_W] = word_inj[DATA_W-1:0];
        o_d[O_PERR]               = pe ^ (^syn);
        o_d[O_SERR]               = 1'b0;
        o_d[O_DERR]               = 1'b0;
      end else begin
        o_d[O_DATA_LSB +: DATA_W] = data_fix;
        o_d[O_PERR]               = pe;
        o_d[O_SERR]               = single_err;
        o_d[O_DERR]               = double_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) o_q <= '0;
    else     o_q <= o_d;
  end

  assign o_out = o_q;

endmodule

// File: tb/tb_c1908_secded.sv
// Directed, table-driven bench for c1908_secded, covering decode, encode,
// injection, hold on idle, and mid-stream reset.
module tb_c1908_secded;

`ifdef C1908_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic [32:0] g_in;
  logic [24:0] o_out;

  int checks;
  int failures;

  typedef struct {
    logic [32:0] g;
    logic [24:0] exp;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  c1908_secded dut (
    .clk   (clk),
    .rst   (rst),
    .g_in  (g_in),
    .o_out (o_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] mk_in(input logic [15:0] d, input logic [5:0] cp,
                                        input logic corr, input logic enc,
                                        input logic [4:0] idx, input logic inj,
                                        input logic [1:0] rsv);
    return {1'b1, rsv, inj, idx, enc, corr, cp, d};
  endfunction

  function automatic logic [24:0] mk_out(input logic [15:0] d, input logic [5:0] ps,
                                         input logic serr, input logic derr);
    return {1'b1, derr, serr, ps, d};
  endfunction

  // Drive on the falling edge, then let the word travel through the pipeline.
  task automatic applyStimulus(input logic [32:0] g, input int edges);
    @(negedge clk);
    g_in = g;
    repeat (edges) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [24:0] exp);
    checks++;
    if (o_out !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", name, o_out, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    g_in     = '0;

    vecs[0]  = '{mk_in(16'h0001, 6'b000000, 1'b0, 1'b1, 5'd0,  1'b0, 2'b00), mk_out(16'h0001, 6'b100011, 1'b0, 1'b0)};
    vecs[1]  = '{mk_in(16'h0001, 6'b100011, 1'b1, 1'b0, 5'd0,  1'b0, 2'b00), mk_out(16'h0001, 6'b000000, 1'b0, 1'b0)};
    vecs[2]  = '{mk_in(16'h0001, 6'b100011, 1'b1, 1'b0, 5'd0,  1'b1, 2'b00), mk_out(16'h0001, 6'b100011, 1'b1, 1'b0)};
    vecs[3]  = '{mk_in(16'h0001, 6'b100011, 1'b0, 1'b0, 5'd0,  1'b1, 2'b00), mk_out(16'h0000, 6'b100011, 1'b1, 1'b0)};
    vecs[4]  = '{mk_in(16'h0002, 6'b100011, 1'b1, 1'b0, 5'd0,  1'b0, 2'b00), mk_out(16'h0002, 6'b000110, 1'b0, 1'b1)};
    vecs[5]  = '{mk_in(16'h0000, 6'b100000, 1'b1, 1'b0, 5'd0,  1'b0, 2'b00), mk_out(16'h0000, 6'b100000, 1'b1, 1'b0)};
    vecs[6]  = '{mk_in(16'h0001, 6'b100011, 1'b1, 1'b0, 5'd17, 1'b1, 2'b00), mk_out(16'h0001, 6'b100010, 1'b1, 1'b0)};
    vecs[7]  = '{mk_in(16'h0001, 6'b100011, 1'b1, 1'b0, 5'd21, 1'b1, 2'b00), mk_out(16'h0001, 6'b100000, 1'b1, 1'b0)};
    vecs[8]  = '{mk_in(16'h0001, 6'b100011, 1'b1, 1'b0, 5'd25, 1'b1, 2'b00), mk_out(16'h0001, 6'b000000, 1'b0, 1'b0)};
    vecs[9]  = '{mk_in(16'h0000, 6'b010110, 1'b1, 1'b0, 5'd0,  1'b0, 2'b00), mk_out(16'h0000, 6'b110110, 1'b0, 1'b1)};
    vecs[10] = '{mk_in(16'h8000, 6'b000000, 1'b0, 1'b1, 5'd0,  1'b0, 2'b00), mk_out(16'h8000, 6'b010101, 1'b0, 1'b0)};
    vecs[11] = '{mk_in(16'hFFFF, 6'b000000, 1'b0, 1'b1, 5'd0,  1'b0, 2'b00), mk_out(16'hFFFF, 6'b011110, 1'b0, 1'b0)};
    vecs[12] = '{mk_in(16'h8000, 6'b010101, 1'b1, 1'b0, 5'd15, 1'b1, 2'b00), mk_out(16'h8000, 6'b110101, 1'b1, 1'b0)};
    vecs[13] = '{mk_in(16'h0001, 6'b100011, 1'b1, 1'b0, 5'd0,  1'b0, 2'b11), mk_out(16'h0001, 6'b000000, 1'b0, 1'b0)};
    vecs[14] = '{mk_in(16'hFFFF, 6'b011110, 1'b1, 1'b0, 5'd7,  1'b1, 2'b00), mk_out(16'hFFFF, 6'b101100, 1'b1, 1'b0)};
    vecs[15] = '{mk_in(16'hFFFF, 6'b011110, 1'b1, 1'b0, 5'd31, 1'b1, 2'b10), mk_out(16'hFFFF, 6'b000000, 1'b0, 1'b0)};

    // Reset overrides a valid word sitting on the input.
    applyStimulus(vecs[1].g, 3);
    checkOutput("reset_state", 25'h0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].g, LAT);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Idle input: fields hold the last result, only out_valid drops.
    applyStimulus({1'b0, 32'hFFFF_FFFF}, LAT);
    checkOutput("hold_idle", {1'b0, vecs[NVEC-1].exp[23:0]});
    applyStimulus({1'b0, 32'h0000_1234}, 1);
    checkOutput("hold_idle2", {1'b0, vecs[NVEC-1].exp[23:0]});

    // Stream words back to back, then reset mid-stream.
    applyStimulus(vecs[4].g, 1);
    applyStimulus(vecs[5].g, LAT);
    checkOutput("stream_before_rst", vecs[5].exp);
    @(negedge clk);
    g_in = vecs[2].g;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_midstream", 25'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    if (LAT == 2) begin
      checkOutput("rst_first_edge_regin", 25'h0);
      @(posedge clk);
      #1;
    end
    checkOutput("after_rst_word", vecs[2].exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/c1908_secded.md
# c1908_secded

Registered 16-bit single-error-correct / double-error-detect (SEC/DED) codec modelled on the ISCAS-85 c1908 function. It packs a 33-bit flat input vector and a 25-bit flat output vector so fault-simulation and random-pattern test harnesses can drive it as a single bus. It sits between a memory/data-path read port and its consumer. It can also generate check bits (encode mode) and inject a one-bit error for self-test.

## Interface
- `DATA_W`, 16, data bits per word
- `HAM_W`, 5, Hamming check bits; plus 1 overall-parity bit
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `g_in`  input  33  [15:0] data; [20:16] Hamming check h0..h4; [21] overall parity; [22] correct_en; [23] encode_mode; [28:24] inject_idx; [29] inject_en; [31:30] reserved, ignored; [32] in_valid
- `o_out`  output  25  [15:0] data_out; [20:16] syndrome, or computed check bits in encode mode; [21] parity_err, or computed overall parity in encode mode; [22] single_err; [23] double_err; [24] out_valid

## Operation
- **Codeword layout:** positions 1..21.
  - Check bit hk sits at position 2^k (1, 2, 4, 8, 16).
  - Data bits 0..15 sit in ascending order at positions 3, 5, 6, 7, 9..15, 17..21.
- **Injection:** if inject_en=1, invert one bit of the 22-bit received word {parity, check, data} before decode.
  - inject_idx 0..15 selects a data bit; 16..20 selects h0..h4; 21 selects parity.
  - inject_idx ≥22 has no effect.
- **Decode** (encode_mode=0):
  - s[k] = XOR of all codeword bits whose position has bit k set.
  - pe = XOR of all 22 received bits.
  - s=0, pe=0: no error; data passes through.
  - pe=1, s=0: the parity bit is in error. single_err=1; data unchanged.
  - pe=1, 1≤s≤21: single_err=1. If position s holds a data bit and correct_en=1, invert that data bit in data_out.
  - pe=1, s≥22: double_err=1; data uncorrected.
  - pe=0, s≠0: double_err=1; data uncorrected.
  - single_err and double_err are never both 1.
- **Encode** (encode_mode=1):
  - data_out = data.
  - [20:16] = Hamming check bits computed from data.
  - [21] = XOR of data and computed check bits.
  - single_err = double_err = 0.
  - Injection applies to data before encode.
- **Reserved bits:** [31:30] have no effect on any output.

## Timing
- One pipeline register; latency 1 cycle.
- A word presented with in_valid=1 at edge N appears on o_out after edge N, with out_valid=1.
- in_valid=0 at an edge:
  - out_valid clears to 0.
  - Fields [23:0] hold their previous values.
- Reset: rst=1 at an edge forces all 25 output bits to 0, overriding in_valid. This applies mid-stream; the word in flight is discarded.
- The first word after reset deasserts is accepted at the first edge with rst=0.
- No backpressure; the block accepts a word every cycle.

## Configuration
- `C1908_INPUT_REG_EN` defined:
  - Adds an input register stage on g_in, also reset synchronously to 0. Latency becomes 2 cycles.
  - in_valid is pipelined with the data.
- Macro not defined: latency 1 as above.
- Function is identical in both builds.

## Structure
- **Shared package `c1908_pkg`:**
  - Width constants: DATA_W, HAM_W, IN_W=33, OUT_W=25.
  - g_in/o_out field index constants.
  - Data-to-codeword position table.
  - Check-bit generation function.
- **Sub-module `c1908_syndrome`:** purely combinational. Takes the 22-bit word after injection and produces s[4:0] and pe. The encoder reuses it with the check inputs zeroed.
- **Top level:** injection, decode/encode muxing, correction, and the output register.

## Test plan
- Encode: g_in data=0x0001, encode_mode=1, in_valid=1 -> next cycle o_out[21:16]=6'b100011, data_out=0x0001, out_valid=1.
- Clean decode: data=0x0001, check/parity=6'b100011, correct_en=1 -> syndrome=0, parity_err=0, single_err=0, double_err=0, data_out=0x0001.
- Single data error: same word, inject_en=1, inject_idx=0 -> syndrome=3, parity_err=1, single_err=1, data_out=0x0001. With correct_en=0 -> data_out=0x0000.
- Double error: data=0x0002, check/parity=6'b100011, no injection -> syndrome=6, parity_err=0, double_err=1, data_out=0x0002.
- Parity-only error: data=0x0000, check/parity=6'b100000 -> syndrome=0, single_err=1, data_out=0x0000.
- Reset mid-stream: stream valid words, assert rst for 1 cycle -> o_out=0 after that edge. Next valid word appears 1 cycle after rst deasserts (2 cycles with `C1908_INPUT_REG_EN`).
